// File: rtl/pipelined_right_shifter_if.sv
// Valid/ready stream bundle for the pipelined right shifter: operand beat in, shifted beat out.
interface pipelined_right_shifter_if #(
    parameter int WIDTH       = 49,
    parameter int COUNT_WIDTH = 6,
    parameter int TAG_WIDTH   = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [COUNT_WIDTH-1:0] shift_count;
    logic [WIDTH-1:0]       operand;
    logic [TAG_WIDTH-1:0]   in_tag;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       result;
    logic                   sticky;
    logic [TAG_WIDTH-1:0]   out_tag;

    modport master (
        output in_valid, shift_count, operand, in_tag, out_ready,
        input  in_ready, out_valid, result, sticky, out_tag
    );

    modport slave (
        input  in_valid, shift_count, operand, in_tag, out_ready,
        output in_ready, out_valid, result, sticky, out_tag
    );
endinterface

// File: rtl/pipelined_right_shifter.sv
// Two-stage logarithmic right shifter for mantissa alignment; collects the OR of all
// shifted-out bits as a sticky flag. Stage 1 handles shifts 1/2/4, stage 2 handles 8/16/32.
module pipelined_right_shifter #(
    parameter int WIDTH       = 49,
    parameter int COUNT_WIDTH = 6,
    parameter int TAG_WIDTH   = 8
) (
    input logic                      clk,
    input logic                      reset,
    pipelined_right_shifter_if.slave bus
);
    localparam int HI_WIDTH = COUNT_WIDTH - 3;

    logic                 s1_valid;
    logic [WIDTH-1:0]     s1_data;
    logic                 s1_sticky;
    logic [HI_WIDTH-1:0]  s1_count_hi;
    logic [TAG_WIDTH-1:0] s1_tag;

    logic                 s2_valid;
    logic [WIDTH-1:0]     s2_data;
    logic                 s2_sticky;
    logic [TAG_WIDTH-1:0] s2_tag;

    logic                   s2_advance;
    logic                   s1_advance;
    logic [2:0]             count_lo;
    logic [WIDTH-1:0]       s1_shifted;
    logic [WIDTH-1:0]       s1_mask;
    logic [COUNT_WIDTH-1:0] s2_amount;
    logic [WIDTH-1:0]       s2_shifted;
    logic [WIDTH-1:0]       s2_mask;

    assign s2_advance = !s2_valid || bus.out_ready;
    assign s1_advance = !s1_valid || s2_advance;

    // Masks are built from all-ones shifted left, so shift amounts past WIDTH
    // naturally select every bit and the shifted data falls to zero.
    assign count_lo   = bus.shift_count[2:0];
    assign s1_shifted = bus.operand >> count_lo;
    assign s1_mask    = ~({WIDTH{1'b1}} << count_lo);

    assign s2_amount  = {s1_count_hi, 3'b000};
    assign s2_shifted = s1_data >> s2_amount;
    assign s2_mask    = ~({WIDTH{1'b1}} << s2_amount);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s1_sticky   <= 1'b0;
            s1_count_hi <= '0;
            s1_tag      <= '0;
        end else if (s1_advance) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_data     <= s1_shifted;
                s1_sticky   <= |(bus.operand & s1_mask);
                s1_count_hi <= bus.shift_count[COUNT_WIDTH-1:3];
                s1_tag      <= bus.in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_sticky <= 1'b0;
            s2_tag    <= '0;
        end else if (s2_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data   <= s2_shifted;
                s2_sticky <= s1_sticky | (|(s1_data & s2_mask));
                s2_tag    <= s1_tag;
            end
        end
    end

    assign bus.in_ready  = s1_advance;
    assign bus.out_valid = s2_valid;
    assign bus.result    = s2_data;
    assign bus.sticky    = s2_sticky;
    assign bus.out_tag   = s2_tag;
endmodule
